// File: rtl/jtmx5k_sndrom_server.sv
// Sound ROM server: three one-word client caches refilled one miss at a time over a 16-bit read bus.
// ST_IDLE | no read outstanding; pick a miss or flush caches while downloading / ST_WAIT | read issued, waiting for mem_rdy
module jtmx5k_sndrom_server #(
    parameter int             ROM_AW      = 15,
    parameter int             PCM_AW      = 18,
    parameter int             MAW         = 22,
    parameter logic [MAW-1:0] ROM_OFFSET  = 22'h0,
    parameter logic [MAW-1:0] PCMA_OFFSET = 22'h4000,
    parameter logic [MAW-1:0] PCMB_OFFSET = 22'h24000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_cs,
    output logic [7:0]        rom_data,
    output logic              rom_ok,
    input  logic [PCM_AW-1:0] pcma_addr,
    input  logic              pcma_cs,
    output logic [7:0]        pcma_dout,
    output logic              pcma_ok,
    input  logic [PCM_AW-1:0] pcmb_addr,
    input  logic              pcmb_cs,
    output logic [7:0]        pcmb_dout,
    output logic              pcmb_ok,
    output logic [MAW-1:0]    mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_din,
    input  logic              mem_rdy
);
    localparam int RTW = ROM_AW - 1;
    localparam int PTW = PCM_AW - 1;
    localparam int TW  = (PTW > RTW) ? PTW : RTW;

    localparam logic [1:0] CL_ROM  = 2'd0;
    localparam logic [1:0] CL_PCMA = 2'd1;
    localparam logic [1:0] CL_PCMB = 2'd2;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       client_q, client_d;
    logic [TW-1:0]    cap_tag_q, cap_tag_d;
    logic [MAW-1:0]   mem_addr_q, mem_addr_d;
    logic             mem_rd_q, mem_rd_d;
    logic             last_b_q, last_b_d;
    logic [15:0]      rom_word_q, rom_word_d, pcma_word_q, pcma_word_d, pcmb_word_q, pcmb_word_d;
    logic [RTW-1:0]   rom_tag_q, rom_tag_d;
    logic [PTW-1:0]   pcma_tag_q, pcma_tag_d, pcmb_tag_q, pcmb_tag_d;
    logic             rom_valid_q, rom_valid_d, pcma_valid_q, pcma_valid_d, pcmb_valid_q, pcmb_valid_d;

    logic rom_hit, pcma_hit, pcmb_hit;
    logic rom_miss, pcma_miss, pcmb_miss;

    assign rom_hit   = rom_cs  && rom_valid_q  && (rom_tag_q  == rom_addr[ROM_AW-1:1]);
    assign pcma_hit  = pcma_cs && pcma_valid_q && (pcma_tag_q == pcma_addr[PCM_AW-1:1]);
    assign pcmb_hit  = pcmb_cs && pcmb_valid_q && (pcmb_tag_q == pcmb_addr[PCM_AW-1:1]);
    assign rom_miss  = rom_cs  && !rom_hit;
    assign pcma_miss = pcma_cs && !pcma_hit;
    assign pcmb_miss = pcmb_cs && !pcmb_hit;

    assign rom_ok    = rom_hit;
    assign pcma_ok   = pcma_hit;
    assign pcmb_ok   = pcmb_hit;
    assign rom_data  = rom_addr[0]  ? rom_word_q[15:8]  : rom_word_q[7:0];
    assign pcma_dout = pcma_addr[0] ? pcma_word_q[15:8] : pcma_word_q[7:0];
    assign pcmb_dout = pcmb_addr[0] ? pcmb_word_q[15:8] : pcmb_word_q[7:0];
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;

    always_comb begin
        state_d      = state_q;
        client_d     = client_q;
        cap_tag_d    = cap_tag_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        last_b_d     = last_b_q;
        rom_word_d   = rom_word_q;
        pcma_word_d  = pcma_word_q;
        pcmb_word_d  = pcmb_word_q;
        rom_tag_d    = rom_tag_q;
        pcma_tag_d   = pcma_tag_q;
        pcmb_tag_d   = pcmb_tag_q;
        rom_valid_d  = rom_valid_q;
        pcma_valid_d = pcma_valid_q;
        pcmb_valid_d = pcmb_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (downloading) begin
                    rom_valid_d  = 1'b0;
                    pcma_valid_d = 1'b0;
                    pcmb_valid_d = 1'b0;
                end else if (rom_miss) begin
                    client_d   = CL_ROM;
                    cap_tag_d  = TW'(rom_addr[ROM_AW-1:1]);
                    mem_addr_d = ROM_OFFSET + MAW'(rom_addr[ROM_AW-1:1]);
                    mem_rd_d   = 1'b1;
                    state_d    = ST_WAIT;
                end else if (pcma_miss && (!pcmb_miss || last_b_q)) begin
                    // last_b_q set means B was served last, so A gets the tie
                    client_d   = CL_PCMA;
                    cap_tag_d  = TW'(pcma_addr[PCM_AW-1:1]);
                    mem_addr_d = PCMA_OFFSET + MAW'(pcma_addr[PCM_AW-1:1]);
                    mem_rd_d   = 1'b1;
                    last_b_d   = 1'b0;
                    state_d    = ST_WAIT;
                end else if (pcmb_miss) begin
                    client_d   = CL_PCMB;
                    cap_tag_d  = TW'(pcmb_addr[PCM_AW-1:1]);
                    mem_addr_d = PCMB_OFFSET + MAW'(pcmb_addr[PCM_AW-1:1]);
                    mem_rd_d   = 1'b1;
                    last_b_d   = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rdy) begin
                    case (client_q)
                        CL_ROM: begin
                            rom_word_d  = mem_din;
                            rom_tag_d   = cap_tag_q[RTW-1:0];
                            rom_valid_d = 1'b1;
                        end
                        CL_PCMA: begin
                            pcma_word_d  = mem_din;
                            pcma_tag_d   = cap_tag_q[PTW-1:0];
                            pcma_valid_d = 1'b1;
                        end
                        CL_PCMB: begin
                            pcmb_word_d  = mem_din;
                            pcmb_tag_d   = cap_tag_q[PTW-1:0];
                            pcmb_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                    mem_rd_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            client_q     <= CL_ROM;
            cap_tag_q    <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            last_b_q     <= 1'b1;
            rom_word_q   <= '0;
            pcma_word_q  <= '0;
            pcmb_word_q  <= '0;
            rom_tag_q    <= '0;
            pcma_tag_q   <= '0;
            pcmb_tag_q   <= '0;
            rom_valid_q  <= 1'b0;
            pcma_valid_q <= 1'b0;
            pcmb_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            client_q     <= client_d;
            cap_tag_q    <= cap_tag_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            last_b_q     <= last_b_d;
            rom_word_q   <= rom_word_d;
            pcma_word_q  <= pcma_word_d;
            pcmb_word_q  <= pcmb_word_d;
            rom_tag_q    <= rom_tag_d;
            pcma_tag_q   <= pcma_tag_d;
            pcmb_tag_q   <= pcmb_tag_d;
            rom_valid_q  <= rom_valid_d;
            pcma_valid_q <= pcma_valid_d;
            pcmb_valid_q <= pcmb_valid_d;
        end
    end
endmodule

// File: tb/tb_jtmx5k_sndrom_server.sv
// Directed bench for jtmx5k_sndrom_server with a latency-programmable memory responder.
module tb_jtmx5k_sndrom_server;
    logic        clk = 1'b0;
    logic        rst, downloading;
    logic [14:0] rom_addr;
    logic        rom_cs, rom_ok;
    logic [7:0]  rom_data;
    logic [17:0] pcma_addr, pcmb_addr;
    logic        pcma_cs, pcma_ok, pcmb_cs, pcmb_ok;
    logic [7:0]  pcma_dout, pcmb_dout;
    logic [21:0] mem_addr;
    logic        mem_rd, mem_rdy;
    logic [15:0] mem_din;

    int          n_tests = 0;
    int          n_fail = 0;
    int          lat = 3;
    int          late_req = 0;
    int          late_done;
    int          resp_err;
    int          cnt;
    logic [21:0] req_addr;

    localparam logic [21:0] OFF_ROM  = 22'h0;
    localparam logic [21:0] OFF_PCMA = 22'h4000;
    localparam logic [21:0] OFF_PCMB = 22'h24000;

    jtmx5k_sndrom_server dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .pcma_addr(pcma_addr), .pcma_cs(pcma_cs), .pcma_dout(pcma_dout), .pcma_ok(pcma_ok),
        .pcmb_addr(pcmb_addr), .pcmb_cs(pcmb_cs), .pcmb_dout(pcmb_dout), .pcmb_ok(pcmb_ok),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [21:0] a);
        logic [15:0] t;
        if (a == 22'h1) return 16'hBEEF;
        t = a[15:0] * 16'd40503;
        return t ^ {10'd0, a[21:16]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [21:0] off, input logic [17:0] ba);
        logic [15:0] w;
        w = mem_word(off + {5'd0, ba[17:1]});
        return ba[0] ? w[15:8] : w[7:0];
    endfunction

    // memory: mem_rdy pulses lat cycles after mem_rd is first seen; protocol slips counted in resp_err
    initial begin
        mem_rdy = 1'b0; mem_din = '0; cnt = 0; req_addr = '0; late_done = 0; resp_err = 0;
        forever begin
            @(posedge clk); #1;
            mem_din = mem_word(mem_addr);
            if (mem_rdy) begin
                mem_rdy = 1'b0;
                cnt = 0;
                if (mem_rd !== 1'b0) resp_err++;
            end else if (late_req != late_done) begin
                late_done = late_req;
                mem_rdy = 1'b1;
            end else if (mem_rd === 1'b1) begin
                if (cnt == 0) req_addr = mem_addr;
                else if (mem_addr !== req_addr) resp_err++;
                cnt++;
                if (cnt >= lat) mem_rdy = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input string tag, output logic [21:0] a);
        int n = 0;
        while (mem_rd !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_req_seen"}, 32'(mem_rd), 1);
        a = mem_addr;
    endtask

    task automatic wait_fill(input string tag);
        int n = 0;
        while (mem_rd !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_fill_done"}, 32'(mem_rd), 0);
    endtask

    initial begin
        logic [21:0] a;
        logic        all_ok;
        rst = 1'b1; downloading = 1'b0;
        rom_cs = 1'b0; pcma_cs = 1'b0; pcmb_cs = 1'b0;
        rom_addr = '0; pcma_addr = '0; pcmb_addr = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rom_ok", 32'(rom_ok), 0);
        check("rst_pcma_ok", 32'(pcma_ok), 0);
        check("rst_pcmb_ok", 32'(pcmb_ok), 0);
        check("rst_rom_data", 32'(rom_data), 0);
        check("rst_pcma_dout", 32'(pcma_dout), 0);
        check("rst_pcmb_dout", 32'(pcmb_dout), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);

        // single ROM miss, latency 3, then a same-word hit on the other byte
        @(negedge clk);
        rom_cs = 1'b1; rom_addr = 15'h0003;
        #1;
        check("t1_ok_at_issue", 32'(rom_ok), 0);
        check("t1_rd_at_issue", 32'(mem_rd), 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("t1_rd_rise", 32'(mem_rd), 1);
                check("t1_mem_addr", 32'(mem_addr), 32'h1);
            end
            check("t1_ok_latency", 32'(rom_ok), (i == 4) ? 1 : 0);
        end
        check("t1_rom_data_hi", 32'(rom_data), 32'hBE);
        check("t1_rd_dropped", 32'(mem_rd), 0);
        rom_addr = 15'h0002;
        #1;
        check("t1_hit_ok", 32'(rom_ok), 1);
        check("t1_hit_data_lo", 32'(rom_data), 32'hEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_no_new_rd", 32'(mem_rd), 0);
        end

        // three simultaneous misses: rom, then A (last served reset to B), then B
        rom_addr = 15'h0010; pcma_cs = 1'b1; pcma_addr = 18'h20; pcmb_cs = 1'b1; pcmb_addr = 18'h30;
        wait_req("t2_a", a);
        check("t2_first_addr", 32'(a), 32'h8);
        wait_fill("t2_a");
        check("t2_rom_ok", 32'(rom_ok), 1);
        check("t2_pcma_not_yet", 32'(pcma_ok), 0);
        check("t2_pcmb_not_yet", 32'(pcmb_ok), 0);
        check("t2_rom_data", 32'(rom_data), 32'(exp_byte(OFF_ROM, 18'h10)));
        wait_req("t2_b", a);
        check("t2_second_addr", 32'(a), 32'h4010);
        wait_fill("t2_b");
        check("t2_pcma_ok", 32'(pcma_ok), 1);
        check("t2_pcmb_still_0", 32'(pcmb_ok), 0);
        check("t2_pcma_dout", 32'(pcma_dout), 32'(exp_byte(OFF_PCMA, 18'h20)));
        wait_req("t2_c", a);
        check("t2_third_addr", 32'(a), 32'h24018);
        wait_fill("t2_c");
        check("t2_pcmb_ok", 32'(pcmb_ok), 1);
        check("t2_pcmb_dout", 32'(pcmb_dout), 32'(exp_byte(OFF_PCMB, 18'h30)));

        // PCM A address moves while its fetch is outstanding
        pcma_addr = 18'h100;
        wait_req("t3_a", a);
        check("t3_first_addr", 32'(a), 32'h4080);
        pcma_addr = 18'h200;
        wait_fill("t3_a");
        check("t3_stale_not_ok", 32'(pcma_ok), 0);
        wait_req("t3_b", a);
        check("t3_refetch_addr", 32'(a), 32'h4100);
        wait_fill("t3_b");
        check("t3_pcma_ok", 32'(pcma_ok), 1);
        check("t3_pcma_dout", 32'(pcma_dout), 32'(exp_byte(OFF_PCMA, 18'h200)));
        check("t3_rom_untouched", 32'(rom_ok), 1);
        check("t3_pcmb_untouched", 32'(pcmb_ok), 1);

        // reset in the middle of a fetch, then a stray mem_rdy while idle
        lat = 10;
        rom_addr = 15'h0040;
        wait_req("t4_a", a);
        check("t4_addr", 32'(a), 32'h20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rd_cleared", 32'(mem_rd), 0);
        check("t4_addr_cleared", 32'(mem_addr), 0);
        check("t4_rom_ok_0", 32'(rom_ok), 0);
        check("t4_pcma_ok_0", 32'(pcma_ok), 0);
        check("t4_pcmb_ok_0", 32'(pcmb_ok), 0);
        rom_cs = 1'b0; pcma_cs = 1'b0; pcmb_cs = 1'b0;
        late_req++;
        repeat (3) @(negedge clk);
        rom_cs = 1'b1; rom_addr = 15'h0001;
        #1;
        check("t4_late_rdy_ignored", 32'(rom_ok), 0);
        check("t4_idle_rd", 32'(mem_rd), 0);
        lat = 2;
        wait_req("t4_b", a);
        check("t4_fresh_addr", 32'(a), 32'h0);
        wait_fill("t4_b");
        check("t4_rom_ok", 32'(rom_ok), 1);
        check("t4_rom_data", 32'(rom_data), 32'(exp_byte(OFF_ROM, 18'h1)));

        // downloading flushes every cache; refetch order rom, A, B
        lat = 4;
        rom_addr = 15'h0040; pcma_cs = 1'b1; pcma_addr = 18'h200; pcmb_cs = 1'b1; pcmb_addr = 18'h30;
        all_ok = 1'b0;
        for (int n = 0; n < 300 && !all_ok; n++) begin
            @(negedge clk);
            all_ok = rom_ok && pcma_ok && pcmb_ok;
        end
        check("t5_all_filled", 32'(all_ok), 1);
        downloading = 1'b1;
        @(negedge clk);
        check("t5_rom_flushed", 32'(rom_ok), 0);
        check("t5_pcma_flushed", 32'(pcma_ok), 0);
        check("t5_pcmb_flushed", 32'(pcmb_ok), 0);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_rd_downloading", 32'(mem_rd), 0);
            @(negedge clk);
        end
        downloading = 1'b0;
        wait_req("t5_a", a);
        check("t5_refetch_rom", 32'(a), 32'h20);
        wait_fill("t5_a");
        wait_req("t5_b", a);
        check("t5_refetch_pcma", 32'(a), 32'h4100);
        wait_fill("t5_b");
        wait_req("t5_c", a);
        check("t5_refetch_pcmb", 32'(a), 32'h24018);
        wait_fill("t5_c");
        check("t5_all_ok_again", 32'(rom_ok && pcma_ok && pcmb_ok), 1);

        // latency sweep with random addresses, every valid byte checked against the memory image
        for (int l = 1; l <= 20; l++) begin
            lat = l;
            for (int r = 0; r < 3; r++) begin
                rom_addr  = 15'($urandom_range(0, 32'h7FFF));
                pcma_addr = 18'($urandom_range(0, 32'h3FFFF));
                pcmb_addr = 18'($urandom_range(0, 32'h3FFFF));
                all_ok = 1'b0;
                for (int n = 0; n < 300 && !all_ok; n++) begin
                    @(negedge clk);
                    if (rom_ok)
                        check("t6_rom_byte", 32'(rom_data), 32'(exp_byte(OFF_ROM, {3'd0, rom_addr})));
                    if (pcma_ok)
                        check("t6_pcma_byte", 32'(pcma_dout), 32'(exp_byte(OFF_PCMA, pcma_addr)));
                    if (pcmb_ok)
                        check("t6_pcmb_byte", 32'(pcmb_dout), 32'(exp_byte(OFF_PCMB, pcmb_addr)));
                    all_ok = rom_ok && pcma_ok && pcmb_ok;
                end
                check("t6_round_complete", 32'(all_ok), 1);
            end
        end

        check("bus_protocol_errors", 32'(resp_err), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
